// File: rtl/data_checker.sv
// Burst integrity checker: after an arm edge, counts DATA_AMOUNT valid words and
// flags every word that is not the previous word plus one.
module data_checker #(
  parameter int unsigned DATA_AMOUNT = 4096,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             arm_in,
  input  logic [31:0]      data_in,
  input  logic             valid_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [ERR_W-1:0] err_count_out,
  output logic [15:0]      first_err_idx_out,
  output logic [15:0]      word_count_out,
  output logic             overrun_out
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    CHECK,
    DONE
  } state_t;

  state_t      state;
  logic        arm_q;
  logic        arm_prev;
  logic        arm_primed;
  logic        arm_tick;
  logic [31:0] expected;
  logic [31:0] data_next;
  logic        mismatch;
  logic [16:0] count_inc;
  logic        last_word;
  logic        err_full;

  // The first sample after reset loads both history stages, so a level that is
  // already high when reset lifts never looks like a rising edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      arm_q      <= 1'b0;
      arm_prev   <= 1'b0;
      arm_primed <= 1'b0;
    end else begin
      arm_q      <= arm_in;
      arm_prev   <= arm_primed ? arm_q : arm_in;
      arm_primed <= 1'b1;
    end
  end

  assign arm_tick  = arm_q & ~arm_prev;
  assign data_next = data_in + 32'd1;
  assign mismatch  = (data_in != expected);
  assign count_inc = {1'b0, word_count_out} + 17'd1;
  assign last_word = (count_inc == 17'(DATA_AMOUNT));
  assign err_full  = &err_count_out;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= IDLE;
      expected          <= 32'd0;
      busy_out          <= 1'b0;
      done_out          <= 1'b0;
      pass_out          <= 1'b0;
      err_count_out     <= '0;
      word_count_out    <= 16'd0;
      first_err_idx_out <= 16'hFFFF;
      overrun_out       <= 1'b0;
    end else if (arm_tick) begin
      // An arm tick wins over everything, including a word arriving in the same cycle.
      state             <= WAIT_FIRST;
      busy_out          <= 1'b1;
      done_out          <= 1'b0;
      pass_out          <= 1'b0;
      err_count_out     <= '0;
      word_count_out    <= 16'd0;
      first_err_idx_out <= 16'hFFFF;
      overrun_out       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (valid_in) begin
            overrun_out <= 1'b1;
          end
        end
        WAIT_FIRST: begin
          if (valid_in) begin
            expected       <= data_next;
            word_count_out <= 16'd1;
            state          <= CHECK;
          end
        end
        CHECK: begin
          if (valid_in) begin
            expected       <= data_next;
            word_count_out <= count_inc[15:0];
            if (mismatch) begin
              if (!err_full) begin
                err_count_out <= err_count_out + ERR_W'(1);
              end
              if (first_err_idx_out == 16'hFFFF) begin
                first_err_idx_out <= word_count_out;
              end
            end
            // Pass is decided from the count including this final word's result.
            if (last_word) begin
              state    <= DONE;
              busy_out <= 1'b0;
              done_out <= 1'b1;
              pass_out <= (err_count_out == '0) && !mismatch;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_checker.sv
// Randomised bench for data_checker: a burst-level model is checked against the
// DUT on every cycle, with literal expectations pinning the key scenarios.
module tb_data_checker;

  localparam int DATA_AMOUNT = 4096;
  localparam int ERR_W       = 16;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             arm_in;
  logic [31:0]      data_in;
  logic             valid_in;
  logic             busy_out;
  logic             done_out;
  logic             pass_out;
  logic [ERR_W-1:0] err_count_out;
  logic [15:0]      first_err_idx_out;
  logic [15:0]      word_count_out;
  logic             overrun_out;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  data_checker #(
    .DATA_AMOUNT(DATA_AMOUNT),
    .ERR_W      (ERR_W)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .arm_in           (arm_in),
    .data_in          (data_in),
    .valid_in         (valid_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .pass_out         (pass_out),
    .err_count_out    (err_count_out),
    .first_err_idx_out(first_err_idx_out),
    .word_count_out   (word_count_out),
    .overrun_out      (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // Burst-level view: arm samples seen, whether a burst is open, and its tallies.
  typedef struct {
    int          n_samp;
    bit          s_last;
    bit          s_prev;
    bit          busy;
    bit          seeded;
    bit          done;
    bit          overrun;
    int          words;
    int          errs;
    int          first;
    logic [31:0] exp;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.n_samp  = 0;
    r.s_last  = 1'b0;
    r.s_prev  = 1'b0;
    r.busy    = 1'b0;
    r.seeded  = 1'b0;
    r.done    = 1'b0;
    r.overrun = 1'b0;
    r.words   = 0;
    r.errs    = 0;
    r.first   = 16'hFFFF;
    r.exp     = 32'd0;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, bit arm, bit vld, logic [31:0] d);
    model_t n = c;
    bit tick = (c.n_samp >= 2) && c.s_last && !c.s_prev;
    if (tick) begin
      n.busy    = 1'b1;
      n.seeded  = 1'b0;
      n.done    = 1'b0;
      n.words   = 0;
      n.errs    = 0;
      n.first   = 16'hFFFF;
      n.overrun = 1'b0;
    end else if (vld) begin
      if (!c.busy) begin
        n.overrun = 1'b1;
      end else if (!c.seeded) begin
        n.seeded = 1'b1;
        n.exp    = d + 32'd1;
        n.words  = 1;
      end else begin
        if (d !== c.exp) begin
          if (c.errs < 65535) n.errs = c.errs + 1;
          if (c.first == 16'hFFFF) n.first = c.words;
        end
        n.words = c.words + 1;
        n.exp   = d + 32'd1;
        if (n.words == DATA_AMOUNT) begin
          n.busy = 1'b0;
          n.done = 1'b1;
        end
      end
    end
    n.s_prev = c.s_last;
    n.s_last = arm;
    if (c.n_samp < 2) n.n_samp = c.n_samp + 1;
    return n;
  endfunction

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) m <= model_reset();
    else           m <= model_step(m, arm_in, valid_in, data_in);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  always @(negedge clk_in) begin
    if (cmp_en) begin
      checkOutput("busy",      32'(busy_out),          32'(m.busy));
      checkOutput("done",      32'(done_out),          32'(m.done));
      checkOutput("pass",      32'(pass_out),          32'(m.done && m.errs == 0));
      checkOutput("err_count", 32'(err_count_out),     32'(m.errs));
      checkOutput("first_err", 32'(first_err_idx_out), 32'(m.first));
      checkOutput("words",     32'(word_count_out),    32'(m.words));
      checkOutput("overrun",   32'(overrun_out),       32'(m.overrun));
    end
  end

  task automatic applyStimulus(input bit vld, input logic [31:0] d);
    @(negedge clk_in);
    valid_in = vld;
    data_in  = d;
  endtask

  task automatic do_arm(input bit word_in_tick);
    @(negedge clk_in);
    arm_in   = 1'b1;
    valid_in = 1'b0;
    @(negedge clk_in);
    valid_in = word_in_tick;
    data_in  = $urandom;
    @(negedge clk_in);
    arm_in   = 1'b0;
    valid_in = 1'b0;
  endtask

  // Sends seed+i for each index, optionally corrupting one index or random ones.
  task automatic send_burst(input logic [31:0] seed, input int nwords, input int bad_idx,
                            input logic [31:0] bad_val, input int max_gap, input bit rand_bad);
    logic [31:0] w;
    for (int i = 0; i < nwords; i++) begin
      repeat ($urandom_range(0, max_gap)) applyStimulus(1'b0, $urandom);
      w = seed + 32'(i);
      if (i == bad_idx) w = bad_val;
      if (rand_bad && ($urandom_range(0, 199) == 0)) w = $urandom;
      applyStimulus(1'b1, w);
    end
    applyStimulus(1'b0, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_busy"},    32'(busy_out),          32'd0);
    checkOutput({tag, "_done"},    32'(done_out),          32'd0);
    checkOutput({tag, "_pass"},    32'(pass_out),          32'd0);
    checkOutput({tag, "_err"},     32'(err_count_out),     32'd0);
    checkOutput({tag, "_words"},   32'(word_count_out),    32'd0);
    checkOutput({tag, "_first"},   32'(first_err_idx_out), 32'hFFFF);
    checkOutput({tag, "_overrun"}, 32'(overrun_out),       32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n_in = 1'b0;
    arm_in   = 1'b1;
    valid_in = 1'b0;
    data_in  = 32'd0;
    repeat (3) @(negedge clk_in);
    cmp_en = 1'b1;
    #2 rst_n_in = 1'b1;

    // Arm already high when reset lifts must not start a burst.
    repeat (5) @(negedge clk_in);
    check_reset_values("arm_high_release");
    arm_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // Words in IDLE raise overrun without touching the counters.
    repeat (3) applyStimulus(1'b1, $urandom);
    applyStimulus(1'b0, 32'd0);
    checkOutput("idle_overrun", 32'(overrun_out),    32'd1);
    checkOutput("idle_words",   32'(word_count_out), 32'd0);

    do_arm(1'b1);
    checkOutput("arm_clears_overrun", 32'(overrun_out),    32'd0);
    checkOutput("arm_busy",           32'(busy_out),       32'd1);
    checkOutput("arm_ignored_word",   32'(word_count_out), 32'd0);

    send_burst(32'd0, DATA_AMOUNT, -1, 32'd0, 0, 1'b0);
    checkOutput("clean_done",  32'(done_out),          32'd1);
    checkOutput("clean_pass",  32'(pass_out),          32'd1);
    checkOutput("clean_err",   32'(err_count_out),     32'd0);
    checkOutput("clean_words", 32'(word_count_out),    32'd4096);
    checkOutput("clean_first", 32'(first_err_idx_out), 32'hFFFF);
    checkOutput("clean_busy",  32'(busy_out),          32'd0);

    // Words after DONE are overrun and leave the result intact.
    repeat (2) applyStimulus(1'b1, $urandom);
    applyStimulus(1'b0, 32'd0);
    checkOutput("done_overrun", 32'(overrun_out),    32'd1);
    checkOutput("done_words",   32'(word_count_out), 32'd4096);
    checkOutput("done_held",    32'(done_out),       32'd1);

    do_arm(1'b0);
    send_burst(32'hFFFF_FFFE, DATA_AMOUNT, -1, 32'd0, 0, 1'b0);
    checkOutput("wrap_pass", 32'(pass_out), 32'd1);
    checkOutput("wrap_err",  32'(err_count_out), 32'd0);

    do_arm(1'b0);
    send_burst(32'd0, DATA_AMOUNT, 100, 32'hDEAD_0000, 0, 1'b0);
    checkOutput("corrupt_err",   32'(err_count_out),     32'd2);
    checkOutput("corrupt_first", 32'(first_err_idx_out), 32'd100);
    checkOutput("corrupt_pass",  32'(pass_out),          32'd0);
    checkOutput("corrupt_done",  32'(done_out),          32'd1);

    do_arm(1'b0);
    send_burst(32'd0, DATA_AMOUNT, -1, 32'd0, 7, 1'b0);
    checkOutput("gaps_done", 32'(done_out), 32'd1);
    checkOutput("gaps_pass", 32'(pass_out), 32'd1);

    // Abort mid-burst, then a random burst with sporadic corruption.
    do_arm(1'b0);
    send_burst($urandom, 500, -1, 32'd0, 1, 1'b0);
    do_arm(1'b0);
    checkOutput("abort_no_done", 32'(done_out),       32'd0);
    checkOutput("abort_words",   32'(word_count_out), 32'd0);
    send_burst($urandom, DATA_AMOUNT, -1, 32'd0, 1, 1'b1);
    checkOutput("random_done", 32'(done_out), 32'd1);

    // Reset in the middle of a burst discards everything immediately.
    do_arm(1'b0);
    send_burst(32'd7, 1000, -1, 32'd0, 0, 1'b0);
    @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1 check_reset_values("mid_reset");
    @(negedge clk_in);
    #2 rst_n_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checkOutput("post_reset_no_done", 32'(done_out), 32'd0);

    do_arm(1'b0);
    send_burst(32'd0, DATA_AMOUNT, -1, 32'd0, 0, 1'b0);
    checkOutput("rearm_pass",  32'(pass_out),       32'd1);
    checkOutput("rearm_words", 32'(word_count_out), 32'd4096);

    repeat (2) @(negedge clk_in);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
